// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles every bus signal around the RAM port arbiter: the fetch-stage
// request port, the memory-stage request port, the RAM macro port and the
// busy flag. clk and reset stay plain ports on the arbiter.
//
// Handshake (both request ports): a requester raises *_in_req_w with its
// address/we/wdata stable and holds them until it sees *_out_ack_l for one
// cycle. By the cycle after the ack it must either drop the request or
// present the next access; a request still high then is a new access.
// There is no separate ready: the ack is the completion and the acceptance.
//
// Modports:
//   slave  - the arbiter's view (requests and RAM read data in, the rest out)
//   master - the surroundings' view (pipeline stages and RAM macro)
interface mem_port_arbiter_if;
  // fetch stage
  logic        if_in_req_w;
  logic [31:0] if_in_address_w;
  logic [31:0] if_out_data_l;
  logic        if_out_ack_l;
  // memory stage
  logic        mem_in_req_w;
  logic        mem_in_we_w;
  logic [31:0] mem_in_address_w;
  logic [31:0] mem_in_wdata_w;
  logic [31:0] mem_out_data_l;
  logic        mem_out_ack_l;
  // RAM macro
  logic        ram_out_en_l;
  logic        ram_out_we_l;
  logic [31:0] ram_out_address_l;
  logic [31:0] ram_out_wdata_l;
  logic [31:0] ram_in_rdata_w;
  // status
  logic        arb_out_busy_l;

  modport slave (
    input  if_in_req_w, if_in_address_w,
    output if_out_data_l, if_out_ack_l,
    input  mem_in_req_w, mem_in_we_w, mem_in_address_w, mem_in_wdata_w,
    output mem_out_data_l, mem_out_ack_l,
    output ram_out_en_l, ram_out_we_l, ram_out_address_l, ram_out_wdata_l,
    input  ram_in_rdata_w,
    output arb_out_busy_l
  );

  modport master (
    output if_in_req_w, if_in_address_w,
    input  if_out_data_l, if_out_ack_l,
    output mem_in_req_w, mem_in_we_w, mem_in_address_w, mem_in_wdata_w,
    input  mem_out_data_l, mem_out_ack_l,
    input  ram_out_en_l, ram_out_we_l, ram_out_address_l, ram_out_wdata_l,
    output ram_in_rdata_w,
    input  arb_out_busy_l
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported RAM between the fetch stage (read-only) and the
// memory stage (read/write). One access at a time runs through
// IDLE -> ISSUE -> WAIT (LATENCY cycles) -> ACK -> IDLE. The memory stage wins
// contention, except that after MAX_MEM_BURST consecutive contended memory
// grants the fetch stage is forced through.
//
// Parameters:
//   LATENCY       1..15  cycles from the RAM sampling en to valid rdata
//   MAX_MEM_BURST 1..15  contended memory grants allowed before fetch wins
// Ports:
//   clk        single clock, rising edge
//   reset      asynchronous, active-low
//   bus        mem_port_arbiter_if.slave (request ports, RAM port, busy)
//   dbg_state  current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 ACK)
// All bus outputs are registered.
module mem_port_arbiter #(
  parameter int LATENCY       = 2,
  parameter int MAX_MEM_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  localparam logic [3:0] LAT_CNT     = 4'(LATENCY);
  localparam logic [3:0] BURST_LIMIT = 4'(MAX_MEM_BURST);

  state_t     state;
  state_t     state_next;
  logic [3:0] wait_cnt;
  logic [3:0] burst_cnt;
  logic       owner_mem;   // 1: the access in flight belongs to the memory stage
  logic       grant_mem;
  logic       grant_if;

  assign dbg_state = state;

  // Next state and grant decision. Requests only matter in IDLE.
  always_comb begin
    state_next = state;
    grant_mem  = 1'b0;
    grant_if   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.mem_in_req_w &&
            !(bus.if_in_req_w && (burst_cnt == BURST_LIMIT))) begin
          grant_mem  = 1'b1;
          state_next = S_ISSUE;
        end else if (bus.if_in_req_w) begin
          grant_if   = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (wait_cnt == 4'd1) state_next = S_ACK;
      S_ACK:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Datapath and registered outputs. Strobes are computed from state_next so
  // they line up with the state they describe while still coming from flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt              <= 4'd0;
      burst_cnt             <= 4'd0;
      owner_mem             <= 1'b0;
      bus.ram_out_en_l      <= 1'b0;
      bus.ram_out_we_l      <= 1'b0;
      bus.ram_out_address_l <= 32'd0;
      bus.ram_out_wdata_l   <= 32'd0;
      bus.if_out_data_l     <= 32'd0;
      bus.if_out_ack_l      <= 1'b0;
      bus.mem_out_data_l    <= 32'd0;
      bus.mem_out_ack_l     <= 1'b0;
      bus.arb_out_busy_l    <= 1'b0;
    end else begin
      bus.ram_out_en_l   <= (state_next == S_ISSUE);
      bus.arb_out_busy_l <= (state_next != S_IDLE);
      bus.if_out_ack_l   <= (state_next == S_ACK) && !owner_mem;
      bus.mem_out_ack_l  <= (state_next == S_ACK) && owner_mem;

      // The RAM command registers hold from ISSUE until the next grant.
      // A fetch grant drives we=0 and wdata=0: fetch has no write data.
      if (grant_mem) begin
        owner_mem             <= 1'b1;
        bus.ram_out_address_l <= bus.mem_in_address_w;
        bus.ram_out_we_l      <= bus.mem_in_we_w;
        bus.ram_out_wdata_l   <= bus.mem_in_wdata_w;
      end else if (grant_if) begin
        owner_mem             <= 1'b0;
        bus.ram_out_address_l <= bus.if_in_address_w;
        bus.ram_out_we_l      <= 1'b0;
        bus.ram_out_wdata_l   <= 32'd0;
      end

      // Contended memory grants count towards the burst limit; any fetch
      // grant restarts it; uncontended memory grants leave it alone.
      if (grant_if) begin
        burst_cnt <= 4'd0;
      end else if (grant_mem && bus.if_in_req_w) begin
        burst_cnt <= burst_cnt + 4'd1;
      end

      if (state == S_ISSUE) begin
        wait_cnt <= LAT_CNT;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      // Read data is valid on the last WAIT cycle; stores capture nothing.
      if ((state == S_WAIT) && (wait_cnt == 4'd1)) begin
        if (!owner_mem) begin
          bus.if_out_data_l <= bus.ram_in_rdata_w;
        end else if (!bus.ram_out_we_l) begin
          bus.mem_out_data_l <= bus.ram_in_rdata_w;
        end
      end
    end
  end

endmodule
